// File: rtl/acc_pkg.sv
`timescale 1ns/1ps
// Shared accumulator-path definitions: source-select codes, FSM states, default sizing.
// Also used by the controller and the accumulator source mux.
package acc_pkg;

    localparam int ACC_DW_DEF      = 8;
    localparam int MEM_TIMEOUT_DEF = 16;

    localparam logic [1:0] SRC_IMM = 2'd0;
    localparam logic [1:0] SRC_REG = 2'd1;
    localparam logic [1:0] SRC_MEM = 2'd2;
    localparam logic [1:0] SRC_ALU = 2'd3;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } acc_state_t;

endpackage

// File: rtl/acc_reg_stage_if.sv
`timescale 1ns/1ps
// Accumulator stage bus: mux data/control in, registered value, flags and stall out.
// Master is the controller/mux side, slave is the accumulator register.
interface acc_reg_stage_if
    import acc_pkg::*;
#(
    parameter int DW = ACC_DW_DEF
);
    logic [DW-1:0] acc_din;
    logic [1:0]    src_sel;
    logic          acc_we;
    logic          mem_valid;
    logic          err_clr;
    logic [DW-1:0] acc_q;
    logic          zero_flag;
    logic          neg_flag;
    logic          stall;
    logic          mem_timeout_err;

    modport master (
        output acc_din, src_sel, acc_we, mem_valid, err_clr,
        input  acc_q, zero_flag, neg_flag, stall, mem_timeout_err
    );

    modport slave (
        input  acc_din, src_sel, acc_we, mem_valid, err_clr,
        output acc_q, zero_flag, neg_flag, stall, mem_timeout_err
    );
endinterface

// File: rtl/acc_reg_stage_mem_wait_timer.sv
`timescale 1ns/1ps
// Memory-wait cycle counter: start loads 1, runs while non-zero, clear returns to 0.
// Latency 0 on expired (pure decode of the count); no backpressure.
module mem_wait_timer
    import acc_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic clear,
    output logic expired
);
    localparam int            CW   = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= CW'(1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expired = (r_cnt == LAST);

endmodule

// File: rtl/acc_reg_stage.sv
`timescale 1ns/1ps
// Accumulator register with zero/neg flags; non-memory writes land 1 cycle after acc_we.
// Backpressure: stall holds fetch while a memory load waits, aborted after MEM_TIMEOUT cycles.
module acc_reg_stage
    import acc_pkg::*;
#(
    parameter int DW          = ACC_DW_DEF,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    acc_reg_stage_if.slave bus
);
    acc_state_t    r_state;
    logic [DW-1:0] r_acc;
    logic          r_zero;
    logic          r_neg;
    logic          r_err;

    logic w_is_idle;
    logic w_is_wait;
    logic w_start;
    logic w_cap;
    logic w_expired;
    logic w_timeout;
    logic w_clear;

    assign w_is_idle = (r_state == IDLE);
    assign w_is_wait = (r_state == WAIT_MEM);
    assign w_start   = w_is_idle && bus.acc_we && (bus.src_sel == SRC_MEM) && !bus.mem_valid;
    assign w_cap     = (w_is_idle && bus.acc_we && !w_start) || (w_is_wait && bus.mem_valid);
    assign w_timeout = w_is_wait && !bus.mem_valid && w_expired;
    assign w_clear   = w_is_wait && (bus.mem_valid || w_expired);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_start),
        .clear   (w_clear),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_zero  <= 1'b1;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE:     if (w_start) r_state <= WAIT_MEM;
                WAIT_MEM: if (w_clear) r_state <= IDLE;
                default:  r_state <= IDLE;
            endcase
            if (w_cap) begin
                r_acc  <= bus.acc_din;
                r_zero <= (bus.acc_din == '0);
                r_neg  <= bus.acc_din[DW-1];
            end
            // A timeout on the same edge as err_clr must stay visible.
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign bus.acc_q           = r_acc;
    assign bus.zero_flag       = r_zero;
    assign bus.neg_flag        = r_neg;
    assign bus.mem_timeout_err = r_err;
    assign bus.stall           = reset_n && (w_start || (w_is_wait && !bus.mem_valid));

endmodule

// File: tb/tb_acc_reg_stage.sv
`timescale 1ns/1ps
// Self-checking bench for acc_reg_stage: directed scenarios plus randomized traffic vs a load-level model.
module tb_acc_reg_stage;
    import acc_pkg::*;

    localparam int DW = 8;
    localparam int TO = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    acc_reg_stage_if #(.DW(DW)) tif ();

    acc_reg_stage #(
        .DW          (DW),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (tif)
    );

    always #5 clk = ~clk;

    // Model: accumulator contents, sticky error, and an outstanding load with its stall-cycle count.
    logic [DW-1:0] m_acc;
    bit            m_err;
    bit            m_pend;
    int            m_wait;
    bit            m_cap;
    bit            m_to;

    function automatic bit exp_stall();
        if (!reset_n) return 1'b0;
        if (m_pend) return !tif.mem_valid;
        return tif.acc_we && (tif.src_sel == SRC_MEM) && !tif.mem_valid;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_acc  = '0;
            m_err  = 1'b0;
            m_pend = 1'b0;
            m_wait = 0;
        end else begin
            m_cap = 1'b0;
            m_to  = 1'b0;
            if (m_pend) begin
                if (tif.mem_valid) m_cap = 1'b1;
                else if (m_wait + 1 >= TO) m_to = 1'b1;
                else m_wait = m_wait + 1;
                if (m_cap || m_to) begin
                    m_pend = 1'b0;
                    m_wait = 0;
                end
            end else if (tif.acc_we) begin
                if (tif.src_sel != SRC_MEM || tif.mem_valid) m_cap = 1'b1;
                else begin
                    m_pend = 1'b1;
                    m_wait = 1;
                end
            end
            if (m_cap) m_acc = tif.acc_din;
            if (m_to) m_err = 1'b1;
            else if (tif.err_clr) m_err = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            chk("acc_q",     32'(tif.acc_q),           32'(m_acc));
            chk("zero_flag", 32'(tif.zero_flag),       32'(m_acc == '0));
            chk("neg_flag",  32'(tif.neg_flag),        32'(m_acc[DW-1]));
            chk("stall",     32'(tif.stall),           32'(exp_stall()));
            chk("err",       32'(tif.mem_timeout_err), 32'(m_err));
        end
    end

    task automatic drive(input logic we, input logic [1:0] sel, input logic [DW-1:0] din,
                         input logic v, input logic clr);
        tif.acc_we    = we;
        tif.src_sel   = sel;
        tif.acc_din   = din;
        tif.mem_valid = v;
        tif.err_clr   = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int nst;

    initial begin
        drive(1'b0, SRC_IMM, 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        reset_n = 1'b1;
        chk("rst_acc",  32'(tif.acc_q), 32'h00);
        chk("rst_zero", 32'(tif.zero_flag), 32'd1);
        chk("rst_neg",  32'(tif.neg_flag), 32'd0);
        chk("rst_err",  32'(tif.mem_timeout_err), 32'd0);

        // Asynchronous reset mid-cycle with a non-zero accumulator.
        drive(1'b1, SRC_IMM, 8'h5A, 1'b0, 1'b0);
        tick();
        chk("pre_rst_acc", 32'(tif.acc_q), 32'h5A);
        drive(1'b0, SRC_IMM, 8'h00, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_acc",  32'(tif.acc_q), 32'h00);
        chk("async_rst_zero", 32'(tif.zero_flag), 32'd1);
        chk("async_rst_neg",  32'(tif.neg_flag), 32'd0);
        tick();
        reset_n = 1'b1;

        drive(1'b1, SRC_ALU, 8'h80, 1'b0, 1'b0);
        tick();
        chk("alu_acc",   32'(tif.acc_q), 32'h80);
        chk("alu_neg",   32'(tif.neg_flag), 32'd1);
        chk("alu_zero",  32'(tif.zero_flag), 32'd0);
        chk("model_acc", 32'(m_acc), 32'h80);
        drive(1'b0, SRC_ALU, 8'h11, 1'b0, 1'b0);
        tick();
        chk("hold_acc", 32'(tif.acc_q), 32'h80);

        drive(1'b1, SRC_MEM, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("zw_stall", 32'(tif.stall), 32'd0);
        tick();
        chk("zw_acc",  32'(tif.acc_q), 32'h00);
        chk("zw_zero", 32'(tif.zero_flag), 32'd1);

        // Load with three wait cycles.
        nst = 0;
        drive(1'b1, SRC_MEM, 8'hEE, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) drive(1'b1, SRC_MEM, 8'h3C, 1'b1, 1'b0);
            @(negedge clk);
            if (tif.stall) nst++;
            tick();
        end
        chk("load3_stalls", 32'(nst), 32'd3);
        chk("load3_acc",    32'(tif.acc_q), 32'h3C);
        drive(1'b1, SRC_ALU, 8'h42, 1'b0, 1'b0);
        @(negedge clk);
        chk("load3_idle", 32'(tif.stall), 32'd0);
        tick();
        chk("alu42_acc", 32'(tif.acc_q), 32'h42);

        // Timeout: hold the load until the error appears, then release control.
        nst = 0;
        drive(1'b1, SRC_MEM, 8'h99, 1'b0, 1'b0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tif.stall) nst++;
            tick();
            if (tif.mem_timeout_err) begin
                drive(1'b0, SRC_IMM, 8'h00, 1'b0, 1'b0);
                break;
            end
        end
        @(negedge clk);
        chk("to_stalls",    32'(nst), 32'd16);
        chk("to_err",       32'(tif.mem_timeout_err), 32'd1);
        chk("to_acc",       32'(tif.acc_q), 32'h42);
        chk("to_stall_off", 32'(tif.stall), 32'd0);
        chk("model_err",    32'(m_err), 32'd1);
        tick();
        drive(1'b0, SRC_IMM, 8'h00, 1'b0, 1'b1);
        tick();
        chk("errclr", 32'(tif.mem_timeout_err), 32'd0);
        drive(1'b0, SRC_IMM, 8'h00, 1'b0, 1'b0);

        // Reset during the fifth wait cycle.
        drive(1'b1, SRC_MEM, 8'h55, 1'b0, 1'b0);
        repeat (4) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("wait_rst_stall", 32'(tif.stall), 32'd0);
        drive(1'b0, SRC_IMM, 8'h00, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        chk("wait_rst_acc", 32'(tif.acc_q), 32'h00);
        drive(1'b1, SRC_MEM, 8'h7F, 1'b1, 1'b0);
        @(negedge clk);
        chk("post_rst_stall", 32'(tif.stall), 32'd0);
        tick();
        chk("post_rst_acc", 32'(tif.acc_q), 32'h7F);
        chk("post_rst_neg", 32'(tif.neg_flag), 32'd0);

        // Randomized traffic; while a load is outstanding control holds acc_we/src_sel.
        for (int i = 0; i < 3000; i++) begin
            if (m_pend)
                drive(1'b1, SRC_MEM, 8'($urandom), ($urandom % 6) == 0, ($urandom % 8) == 0);
            else
                drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                      1'($urandom_range(0, 1)), ($urandom % 8) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
